fifo_word_packer: RTL and testbench
===================================

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 Parameter SIZE, default 8, width of one FIFO entry in bits.
REQ-002 Parameter LANES, default 4, number of entries packed into one output word; LANES SHALL be in the range 2..8.
REQ-003 read_clock  input  1  sole clock; the block lives entirely in the FIFO read domain.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 fifo_data  input  SIZE  FIFO data_out, valid the cycle after a fifo_read pop.
REQ-006 fifo_empty  input  1  FIFO empty_flag.
REQ-007 fifo_almost_empty  input  1  FIFO almost_empty_flag.
REQ-008 fifo_read  output  1  pop strobe to the FIFO, one entry per high cycle.
REQ-009 flush  input  1  single-cycle request to emit any partial word.
REQ-010 word_out  output  SIZE*LANES  packed word; lane 0 occupies bits [SIZE-1:0].
REQ-011 word_count  output  $clog2(LANES+1)  number of valid lanes in word_out (1..LANES).
REQ-012 word_valid  output  1  word_out/word_count hold valid data.
REQ-013 word_ready  input  1  downstream accept.
REQ-014 busy  output  1  high when any lane is captured or a pop is in flight.

Function
REQ-015 The FIFO read latency is fixed at 1 cycle: a pop in cycle N SHALL be captured from fifo_data at the cycle N+1 edge.
REQ-016 The FSM SHALL have exactly three states: FILL, DRAIN, HOLD.
REQ-017 In FILL, fifo_read SHALL be high iff fifo_empty=0 and (captured + in_flight) < LANES.
REQ-018 fifo_read SHALL never be high when fifo_empty=1, in DRAIN, or in HOLD.
REQ-019 fifo_almost_empty=1 SHALL limit in_flight to 0 before the next pop, so at most one pop is issued per two cycles; otherwise pops SHALL issue back-to-back.
REQ-020 Each captured entry SHALL go to lane index = captured count; the count then increments by 1.
REQ-021 FILL -> HOLD SHALL occur on the edge that captures lane LANES-1; word_valid rises that cycle with word_count=LANES.
REQ-022 Flush in FILL with captured>0 SHALL go to DRAIN, or with captured=0 and in_flight=0 SHALL be ignored.
REQ-023 Flush arriving with a pop in flight SHALL still be honoured: DRAIN waits for that capture, then enters HOLD.
REQ-024 DRAIN -> HOLD SHALL occur once in_flight=0; word_count = captured and unused lanes SHALL read 0.
REQ-025 In HOLD, word_out, word_count and word_valid SHALL stay stable until word_valid and word_ready are both high in the same cycle.
REQ-026 On acceptance the FSM SHALL clear captured and zero all lanes, then return to FILL; fifo_read may assert in the following cycle.
REQ-027 Flush asserted in HOLD or DRAIN SHALL be ignored and not queued.
REQ-028 word_ready while word_valid=0 SHALL have no effect.
REQ-029 Throughput with FIFO non-empty, fifo_almost_empty=0 and word_ready tied high SHALL be one word per LANES+2 cycles.

Reset
REQ-030 On reset_n=0, state=FILL, captured=0, in_flight=0, word_out=0, word_count=0, word_valid=0, fifo_read=0, busy=0, all asynchronously.
REQ-031 Reset in any state, including HOLD or with a pop in flight, SHALL discard all partial data; the in-flight FIFO entry is lost by design.
REQ-032 The first fifo_read after deassertion SHALL be no earlier than the second read_clock rising edge.

Structure
REQ-033 A shared package fifo_pkg SHALL hold the state enum (FILL, DRAIN, HOLD), the LANES default and the SIZE default.
REQ-034 One sub-module, fifo_lane_reg, SHALL hold the per-lane register with load, clear and asynchronous reset.

Verification
REQ-035 Reset mid-HOLD: fill a word, hold word_ready=0, pulse reset_n -> word_valid=0, word_out=0, busy=0 immediately; next word starts at lane 0.
REQ-036 Full word: FIFO holds 21,247,90,10 with word_ready=1 -> word_out=0x0A5AF715, word_count=4, word_valid for exactly one cycle, fifo_read high exactly 4 cycles.
REQ-037 Backpressure: FIFO holds 0..7 with word_ready=0 for 10 cycles -> word_out=0x03020100 stable; no fifo_read during HOLD; after accept, 0x07060504 follows.
REQ-038 Partial flush: push 28,29,30, wait until drained, pulse flush -> word_out=0x001E1D1C, word_count=3.
REQ-039 Flush with pop in flight: flush in the cycle after the pop of value 31 with one lane held -> word_count=2 and lane 1=31.
REQ-040 Empty guard: FIFO empty for 50 cycles with a random flush/word_ready pattern -> fifo_read never high and word_valid never high.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state encoding and default geometry for the FIFO word packer.
package fifo_pkg;
  typedef enum logic [1:0] {FILL, DRAIN, HOLD} state_t;
  localparam int LANES_DEF = 4;
  localparam int SIZE_DEF = 8;
endpackage

// File: rtl/fifo_lane_reg.sv
// fifo_lane_reg: one lane of the packed word with load, clear and async reset.
module fifo_lane_reg
  import fifo_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            load,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops FIFO entries into LANES-wide words, with flush and backpressure.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic                       read_clock,
  input  logic                       reset_n,
  input  logic [SIZE-1:0]            fifo_data,
  input  logic                       fifo_empty,
  input  logic                       fifo_almost_empty,
  output logic                       fifo_read,
  input  logic                       flush,
  output logic [SIZE*LANES-1:0]      word_out,
  output logic [$clog2(LANES+1)-1:0] word_count,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic                       busy
);
  localparam int CW = $clog2(LANES+1);
  state_t state, state_nx;
  logic [CW-1:0] captured;
  logic in_flight, armed, accept, last, flush_ok, pop_ok;
  always_ff @(posedge read_clock or negedge reset_n)
    if (!reset_n) state <= FILL;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    accept   = state == HOLD && word_ready;
    last     = in_flight && captured == CW'(LANES-1);
    flush_ok = flush && (captured != '0 || in_flight);
    pop_ok   = armed && !fifo_empty && (int'(captured) + int'(in_flight) < LANES)
             && !(fifo_almost_empty && in_flight);
    fifo_read = state == FILL && pop_ok && !flush_ok;
    case (state)
      FILL:    state_nx = last ? HOLD : flush_ok ? DRAIN : FILL;
      DRAIN:   state_nx = in_flight ? DRAIN : HOLD;
      HOLD:    state_nx = word_ready ? FILL : HOLD;
      default: state_nx = FILL;
    endcase
  end
  // armed holds off the first pop until one edge after reset release
  always_ff @(posedge read_clock or negedge reset_n)
    if (!reset_n) begin
      captured  <= '0;
      in_flight <= 1'b0;
      armed     <= 1'b0;
    end else begin
      armed     <= 1'b1;
      in_flight <= fifo_read;
      captured  <= accept ? '0 : in_flight ? captured + CW'(1) : captured;
    end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fifo_lane_reg #(.SIZE(SIZE)) u_lane (
      .clk  (read_clock),
      .rst_n(reset_n),
      .clr  (accept),
      .load (in_flight && captured == CW'(i)),
      .d    (fifo_data),
      .q    (word_out[i*SIZE +: SIZE])
    );
  end
  assign word_count = captured;
  assign word_valid = state == HOLD;
  assign busy       = captured != '0 || in_flight;
endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: FIFO model plus scoreboard of expected packed words.
module tb_fifo_word_packer;
  typedef struct {logic [31:0] w; logic [2:0] c;} exp_t;
  logic read_clock = 1'b0, reset_n = 1'b0;
  logic [7:0] fifo_data = '0;
  logic fifo_empty = 1'b1, fifo_almost_empty = 1'b0, fifo_read, flush = 1'b0;
  logic word_valid, word_ready = 1'b0, busy, prev_rd = 1'b0;
  logic [31:0] word_out;
  logic [2:0] word_count;
  exp_t exp_q[$];
  logic [7:0] fifo_q[$], in_q[$];
  int hs_q[$];
  int total = 0, bad = 0, cyc = 0, rd_cnt = 0, wv_cnt = 0, b2b = 0;

  fifo_word_packer #(.SIZE(8), .LANES(4)) dut (
    .read_clock(read_clock), .reset_n(reset_n), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
    .fifo_read(fifo_read), .flush(flush), .word_out(word_out),
    .word_count(word_count), .word_valid(word_valid), .word_ready(word_ready),
    .busy(busy)
  );

  always #5 read_clock = ~read_clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // FIFO with one-cycle read latency; new pushes become visible at the next edge
  always @(posedge read_clock) begin
    cyc <= cyc + 1;
    if (fifo_read) begin
      if (fifo_q.size() == 0) check("pop_on_empty", 1, 0);
      else fifo_data <= fifo_q.pop_front();
    end
    while (in_q.size() > 0) fifo_q.push_back(in_q.pop_front());
    fifo_empty <= fifo_q.size() == 0;
  end

  always @(negedge read_clock) if (reset_n) begin
    exp_t e;
    if (fifo_read) rd_cnt++;
    if (fifo_read && prev_rd) b2b++;
    prev_rd = fifo_read;
    if (word_valid) wv_cnt++;
    if (word_valid && word_ready) begin
      hs_q.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_word", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("word_out", word_out, e.w);
        check("word_count", word_count, e.c);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge read_clock);
  endtask
  task automatic push(input logic [7:0] v);
    in_q.push_back(v);
  endtask
  task automatic expect_word(input logic [31:0] w, input logic [2:0] c);
    exp_t e;
    e.w = w; e.c = c;
    exp_q.push_back(e);
  endtask
  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin tick(1); k++; end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    check("rst_valid", word_valid, 0);
    check("rst_out", word_out, 0);
    check("rst_count", word_count, 0);
    check("rst_read", fifo_read, 0);
    check("rst_busy", busy, 0);
    // full word with data queued while still in reset
    word_ready = 1'b1;
    push(8'd21); push(8'd247); push(8'd90); push(8'd10);
    expect_word(32'h0A5AF715, 3'd4);
    tick(2);
    reset_n = 1'b1;
    #1 check("first_read_held", fifo_read, 0);
    drain(40);
    tick(3);
    check("full_rd_cycles", rd_cnt, 4);
    check("full_valid_cycles", wv_cnt, 1);
    // backpressure with an ignored flush during HOLD
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(i));
    expect_word(32'h03020100, 3'd4);
    expect_word(32'h07060504, 3'd4);
    tick(8);
    for (int i = 0; i < 10; i++) begin
      flush = i == 3;
      check("hold_valid", word_valid, 1);
      check("hold_out", word_out, 32'h03020100);
      check("hold_read", fifo_read, 0);
      tick(1);
    end
    flush = 1'b0;
    word_ready = 1'b1;
    drain(40);
    // partial flush
    push(8'd28); push(8'd29); push(8'd30);
    tick(10);
    check("partial_no_valid", word_valid, 0);
    expect_word(32'h001E1D1C, 3'd3);
    flush = 1'b1; tick(1); flush = 1'b0;
    drain(20);
    // flush in the cycle after a pop, one lane already held
    push(8'd5);
    tick(6);
    expect_word(32'h00001F05, 3'd2);
    push(8'd31);
    begin
      int k = 0;
      while (!fifo_read && k < 10) begin tick(1); k++; end
    end
    check("pop31_seen", fifo_read, 1);
    tick(1);
    flush = 1'b1; tick(1); flush = 1'b0;
    drain(20);
    // throughput: one word every LANES+2 cycles
    hs_q.delete();
    rd_cnt = 0;
    for (int i = 0; i < 12; i++) push(8'(8'h40 + i));
    expect_word(32'h43424140, 3'd4);
    expect_word(32'h47464544, 3'd4);
    expect_word(32'h4B4A4948, 3'd4);
    drain(80);
    check("hs_count", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      check("gap0", hs_q[1] - hs_q[0], 6);
      check("gap1", hs_q[2] - hs_q[1], 6);
    end
    check("tp_rd_cycles", rd_cnt, 12);
    // almost-empty spacing
    fifo_almost_empty = 1'b1;
    b2b = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    expect_word(32'h44332211, 3'd4);
    drain(40);
    check("ae_back_to_back", b2b, 0);
    fifo_almost_empty = 1'b0;
    // reset while holding a word
    word_ready = 1'b0;
    push(8'd1); push(8'd2); push(8'd3); push(8'd4);
    tick(10);
    check("pre_rst_valid", word_valid, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", word_valid, 0);
    check("mid_rst_out", word_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", word_count, 0);
    tick(1);
    reset_n = 1'b1;
    word_ready = 1'b1;
    push(8'd9); push(8'd8); push(8'd7); push(8'd6);
    expect_word(32'h06070809, 3'd4);
    drain(40);
    // empty FIFO with random flush/ready
    tick(2);
    rd_cnt = 0;
    wv_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      flush = 1'($urandom_range(0, 1));
      word_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    flush = 1'b0;
    check("empty_rd", rd_cnt, 0);
    check("empty_valid", wv_cnt, 0);
    check("leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
